// File: rtl/command_loader.sv
// Command loader: decodes UART command bytes, streams vector bytes into
// BRAM_A / BRAM_B and issues single-cycle commands to the processing stage.
//
// Ports:
//   clk, reset          system clock, synchronous active-high reset
//   rx_ready, rx_data   received UART byte strobe and data
//   done                completion pulse from the processing stage
//   bram_we_a/b         write enables for the two BRAM write ports
//   bram_addr, wdata    shared write address / data (hold when idle)
//   result              {valid, vector, op[1:0]} command, valid 1 cycle
//   busy                high whenever not in IDLE
//   load_err            one-cycle pulse when a load times out
module command_loader #(
    parameter int NBytes  = 1024,
    parameter int TIMEOUT = 1_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx_ready,
    input  logic [7:0] rx_data,
    input  logic       done,
    output logic       bram_we_a,
    output logic       bram_we_b,
    output logic [9:0] bram_addr,
    output logic [7:0] bram_wdata,
    output logic [3:0] result,
    output logic       busy,
    output logic       load_err
);

    localparam int IW = $clog2(TIMEOUT + 1);
    localparam logic [9:0]    LAST_ADDR = 10'(NBytes - 1);
    localparam logic [IW-1:0] IDLE_LAST = IW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE,
        LOAD_A,
        LOAD_B,
        WAIT_DONE
    } state_t;

    state_t        state, state_n;
    logic [9:0]    byte_cnt, byte_n;
    logic [IW-1:0] idle_cnt, idle_n;
    logic          we_a_n, we_b_n;
    logic [9:0]    addr_n;
    logic [7:0]    wdata_n;
    logic [3:0]    result_n;
    logic          err_n;

    always_comb begin
        state_n  = state;
        byte_n   = byte_cnt;
        idle_n   = idle_cnt;
        we_a_n   = 1'b0;
        we_b_n   = 1'b0;
        addr_n   = bram_addr;
        wdata_n  = bram_wdata;
        result_n = 4'b0000;
        err_n    = 1'b0;

        unique case (state)
            IDLE: begin
                idle_n = '0;
                byte_n = '0;
                if (rx_ready) begin
                    case (rx_data)
                        8'h01: state_n = LOAD_A;
                        8'h02: state_n = LOAD_B;
                        8'h03: begin result_n = 4'b1100; state_n = WAIT_DONE; end
                        8'h04: begin result_n = 4'b1101; state_n = WAIT_DONE; end
                        8'h05: begin result_n = 4'b1110; state_n = WAIT_DONE; end
                        8'h06: begin result_n = 4'b1111; state_n = WAIT_DONE; end
                        8'h07: begin result_n = 4'b1000; state_n = WAIT_DONE; end
                        8'h08: begin result_n = 4'b1001; state_n = WAIT_DONE; end
                        default: ;
                    endcase
                end
            end

            LOAD_A, LOAD_B: begin
                // A byte in the expiry cycle still counts as activity.
                if (rx_ready) begin
                    we_a_n  = (state == LOAD_A);
                    we_b_n  = (state == LOAD_B);
                    addr_n  = byte_cnt;
                    wdata_n = rx_data;
                    idle_n  = '0;
                    if (byte_cnt == LAST_ADDR) begin
                        byte_n  = '0;
                        state_n = IDLE;
                    end else begin
                        byte_n = byte_cnt + 10'd1;
                    end
                end else if (idle_cnt == IDLE_LAST) begin
                    state_n = IDLE;
                    byte_n  = '0;
                    idle_n  = '0;
                    err_n   = 1'b1;
                end else begin
                    idle_n = idle_cnt + 1'b1;
                end
            end

            WAIT_DONE: begin
                if (done) state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            byte_cnt   <= '0;
            idle_cnt   <= '0;
            bram_we_a  <= 1'b0;
            bram_we_b  <= 1'b0;
            bram_addr  <= '0;
            bram_wdata <= '0;
            result     <= '0;
            busy       <= 1'b0;
            load_err   <= 1'b0;
        end else begin
            state      <= state_n;
            byte_cnt   <= byte_n;
            idle_cnt   <= idle_n;
            bram_we_a  <= we_a_n;
            bram_we_b  <= we_b_n;
            bram_addr  <= addr_n;
            bram_wdata <= wdata_n;
            result     <= result_n;
            busy       <= (state_n != IDLE);
            load_err   <= err_n;
        end
    end

endmodule

// File: tb/tb_command_loader.sv
// Bench for command_loader: scoreboard of expected BRAM writes and
// command results, plus scenario tasks with inline checks.
module tb_command_loader;

    localparam int NB = 1024;
    localparam int TO = 50;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       rx_ready = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       done = 1'b0;
    logic       bram_we_a, bram_we_b;
    logic [9:0] bram_addr;
    logic [7:0] bram_wdata;
    logic [3:0] result;
    logic       busy, load_err;

    command_loader #(.NBytes(NB), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .rx_ready(rx_ready), .rx_data(rx_data),
        .done(done), .bram_we_a(bram_we_a), .bram_we_b(bram_we_b),
        .bram_addr(bram_addr), .bram_wdata(bram_wdata), .result(result),
        .busy(busy), .load_err(load_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       a;
        logic       b;
        logic [9:0] addr;
        logic [7:0] data;
    } wr_t;

    wr_t        wq[$];
    logic [3:0] rq[$];
    int n_checks = 0;
    int n_fail = 0;

    always @(negedge clk) begin
        wr_t got, exp;
        logic [3:0] r;
        if (!reset) begin
            if (bram_we_a || bram_we_b) begin
                n_checks++;
                got = {bram_we_a, bram_we_b, bram_addr, bram_wdata};
                if (wq.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_write got %h want none", got);
                end else begin
                    exp = wq.pop_front();
                    if (got !== exp) begin
                        n_fail++;
                        $display("FAIL write got %h want %h", got, exp);
                    end
                end
            end
            if (result !== 4'b0000) begin
                n_checks++;
                if (rq.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_result got %b want 0000", result);
                end else begin
                    r = rq.pop_front();
                    if (result !== r) begin
                        n_fail++;
                        $display("FAIL result got %b want %b", result, r);
                    end
                end
            end
        end
    end

    task automatic send(input logic [7:0] b);
        @(negedge clk);
        rx_ready = 1'b1;
        rx_data  = b;
        @(negedge clk);
        rx_ready = 1'b0;
    endtask

    task automatic exp_wr(input logic a, input int ad, input logic [7:0] d);
        wq.push_back({a, ~a, 10'(ad), d});
    endtask

    task automatic pulse_done();
        @(negedge clk);
        done = 1'b1;
        @(negedge clk);
        done = 1'b0;
    endtask

    task automatic wait_err(output int cyc);
        cyc = 0;
        while (load_err !== 1'b1 && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic drain();
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        logic [26:0] v;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        v = {bram_we_a, bram_we_b, bram_addr, bram_wdata, result, busy, load_err};
        n_checks++;
        if (v !== 27'd0) begin
            n_fail++;
            $display("FAIL reset_outputs got %h want 0", v);
        end
        reset = 1'b0;
    endtask

    task automatic test_unknown_cmd();
        logic [7:0] cmds[4] = '{8'h00, 8'hFF, 8'h09, 8'h80};
        foreach (cmds[i]) begin
            send(cmds[i]);
            @(negedge clk);
            n_checks++;
            if (busy !== 1'b0 || result !== 4'b0000) begin
                n_fail++;
                $display("FAIL unknown_cmd %h got busy=%b result=%b want 0/0000",
                         cmds[i], busy, result);
            end
        end
    endtask

    task automatic test_command_issue();
        logic [7:0] cmds[6] = '{8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
        logic [3:0] res[6] = '{4'b1100, 4'b1101, 4'b1110, 4'b1111, 4'b1000, 4'b1001};
        rq.push_back(4'b1110);
        send(8'h05);
        @(negedge clk);
        n_checks++;
        if (result !== 4'b0000 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL issue_after got result=%b busy=%b want 0000/1", result, busy);
        end
        send(8'h01);
        repeat (3) @(negedge clk);
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL wait_done_discard got busy=%b want 1", busy);
        end
        pulse_done();
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL done_release got busy=%b want 0", busy);
        end
        foreach (cmds[i]) begin
            rq.push_back(res[i]);
            send(cmds[i]);
            @(negedge clk);
            n_checks++;
            if (busy !== 1'b1) begin
                n_fail++;
                $display("FAIL cmd_busy %h got %b want 1", cmds[i], busy);
            end
            pulse_done();
            n_checks++;
            if (busy !== 1'b0) begin
                n_fail++;
                $display("FAIL cmd_done %h got busy=%b want 0", cmds[i], busy);
            end
        end
        drain();
        n_checks++;
        if (rq.size() != 0) begin
            n_fail++;
            $display("FAIL issue_results_left got %0d want 0", rq.size());
        end
    endtask

    task automatic test_full_load();
        send(8'h01);
        pulse_done();
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL load_a_busy got %b want 1", busy);
        end
        for (int i = 0; i < NB; i++) begin
            exp_wr(1'b1, i, 8'(i));
            send(8'(i));
            if (i == 512) begin
                n_checks++;
                if (busy !== 1'b1) begin
                    n_fail++;
                    $display("FAIL load_a_mid_busy got %b want 1", busy);
                end
            end
        end
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL load_a_end_busy got %b want 0", busy);
        end
        drain();
        n_checks++;
        if (wq.size() != 0) begin
            n_fail++;
            $display("FAIL load_a_writes_left got %0d want 0", wq.size());
        end
    endtask

    task automatic test_timeout();
        int cyc;
        send(8'h02);
        for (int i = 0; i < 3; i++) begin
            exp_wr(1'b0, i, 8'hC0 + 8'(i));
            send(8'hC0 + 8'(i));
        end
        wait_err(cyc);
        n_checks++;
        if (cyc != TO) begin
            n_fail++;
            $display("FAIL timeout_delay got %0d want %0d", cyc, TO);
        end
        @(negedge clk);
        n_checks++;
        if (load_err !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_after got err=%b busy=%b want 0/0", load_err, busy);
        end
        send(8'h02);
        exp_wr(1'b0, 0, 8'h5A);
        send(8'h5A);
        wait_err(cyc);
        n_checks++;
        if (cyc != TO) begin
            n_fail++;
            $display("FAIL timeout_reload_delay got %0d want %0d", cyc, TO);
        end
        drain();
        n_checks++;
        if (wq.size() != 0) begin
            n_fail++;
            $display("FAIL timeout_writes_left got %0d want 0", wq.size());
        end
    endtask

    task automatic test_timeout_race();
        int cyc;
        send(8'h01);
        exp_wr(1'b1, 0, 8'h11);
        send(8'h11);
        repeat (TO - 2) @(negedge clk);
        exp_wr(1'b1, 1, 8'hA5);
        send(8'hA5);
        n_checks++;
        if (load_err !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL race_byte_wins got err=%b busy=%b want 0/1", load_err, busy);
        end
        wait_err(cyc);
        n_checks++;
        if (cyc != TO) begin
            n_fail++;
            $display("FAIL race_timeout_delay got %0d want %0d", cyc, TO);
        end
        send(8'h02);
        exp_wr(1'b0, 0, 8'h22);
        send(8'h22);
        repeat (TO) @(negedge clk);
        n_checks++;
        if (load_err !== 1'b1) begin
            n_fail++;
            $display("FAIL late_byte_timeout got err=%b want 1", load_err);
        end
        drain();
        n_checks++;
        if (wq.size() != 0) begin
            n_fail++;
            $display("FAIL race_writes_left got %0d want 0", wq.size());
        end
    endtask

    task automatic test_done_rx_same();
        rq.push_back(4'b1100);
        send(8'h03);
        @(negedge clk);
        done = 1'b1;
        rx_ready = 1'b1;
        rx_data = 8'h01;
        @(negedge clk);
        done = 1'b0;
        rx_ready = 1'b0;
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL done_rx_same got busy=%b want 0", busy);
        end
        rq.push_back(4'b1101);
        send(8'h04);
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL decode_resume got busy=%b want 1", busy);
        end
        pulse_done();
    endtask

    task automatic test_back_to_back();
        int cyc;
        send(8'h02);
        for (int i = 0; i < 8; i++) begin
            exp_wr(1'b0, i, 8'h80 | 8'(i));
            @(negedge clk);
            rx_ready = 1'b1;
            rx_data = 8'h80 | 8'(i);
        end
        @(negedge clk);
        rx_ready = 1'b0;
        pulse_done();
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL done_in_load got busy=%b want 1", busy);
        end
        repeat (2) @(negedge clk);
        n_checks++;
        if ({bram_we_a, bram_we_b, bram_addr, bram_wdata} !== {2'b00, 10'd7, 8'h87}) begin
            n_fail++;
            $display("FAIL hold got we=%b%b addr=%0d data=%h want 00/7/87",
                     bram_we_a, bram_we_b, bram_addr, bram_wdata);
        end
        wait_err(cyc);
        n_checks++;
        if (load_err !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_timeout got err=%b want 1", load_err);
        end
        drain();
        n_checks++;
        if (wq.size() != 0) begin
            n_fail++;
            $display("FAIL b2b_writes_left got %0d want 0", wq.size());
        end
    endtask

    task automatic test_reset_mid();
        int cyc;
        logic [26:0] v;
        send(8'h01);
        for (int i = 0; i < 500; i++) begin
            exp_wr(1'b1, i, 8'(i) ^ 8'h3C);
            send(8'(i) ^ 8'h3C);
        end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        v = {bram_we_a, bram_we_b, bram_addr, bram_wdata, result, busy, load_err};
        n_checks++;
        if (v !== 27'd0) begin
            n_fail++;
            $display("FAIL reset_mid_load got %h want 0", v);
        end
        reset = 1'b0;
        send(8'h01);
        exp_wr(1'b1, 0, 8'h77);
        send(8'h77);
        exp_wr(1'b1, 1, 8'h78);
        send(8'h78);
        wait_err(cyc);
        n_checks++;
        if (cyc != TO) begin
            n_fail++;
            $display("FAIL reload_timeout got %0d want %0d", cyc, TO);
        end
        rq.push_back(4'b1111);
        send(8'h06);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        n_checks++;
        if (busy !== 1'b0 || result !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_mid_wait got busy=%b result=%b want 0/0000", busy, result);
        end
        drain();
        n_checks++;
        if (wq.size() != 0 || rq.size() != 0) begin
            n_fail++;
            $display("FAIL final_queues got %0d/%0d want 0/0", wq.size(), rq.size());
        end
    endtask

    initial begin
        test_reset();
        test_unknown_cmd();
        test_command_issue();
        test_full_load();
        test_timeout();
        test_timeout_race();
        test_done_rx_same();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
